uart_mmio_ctrl: RTL and testbench

Memory-mapped UART controller for the multicycle RISC-V core. It sits on the datapath's peripheral port and decodes the 2-bit device/register select the datapath emits for I/O accesses. It serialises bytes written by stores and deserialises incoming bytes for loads. It also keeps a status word that software polls.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_bit_timer.sv | 39 +++
 rtl/uart_mmio_ctrl.sv | 167 ++++++++++++++++
 tb/tb_uart_mmio_ctrl.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// Module   : uart_pkg
// Purpose  : Shared encodings for the memory-mapped UART controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam logic [1:0] DEV_NONE = 2'b00;
  localparam logic [1:0] DEV_TX   = 2'b01;
  localparam logic [1:0] DEV_RX   = 2'b10;
  localparam logic [1:0] DEV_STAT = 2'b11;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_START = 2'd1,
    T_DATA  = 2'd2,
    T_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_t;

  localparam int ST_TXBUSY  = 0;
  localparam int ST_RXVALID = 1;
  localparam int ST_RXOVR   = 2;
  localparam int ST_FERR    = 3;

endpackage

`default_nettype wire

// File: rtl/uart_bit_timer.sv
//------------------------------------------------------------------------------
// Module   : uart_bit_timer
// Purpose  : Loadable down-counter; tc pulses on the cycle the count is zero.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_bit_timer #(
  parameter  int CLKS_PER_BIT = 434,
  localparam int CW           = $clog2(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          tc
);

  localparam logic [CW-1:0] TOP = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Reaching zero wraps to a full bit period so consecutive bits need no reload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= (cnt == '0) ? TOP : cnt - 1'b1;
    end
  end

  assign tc = en && !load && (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/uart_mmio_ctrl.sv
//------------------------------------------------------------------------------
// Module   : uart_mmio_ctrl
// Purpose  : 8N1 UART with TX_DATA / RX_DATA / STATUS registers for the core.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_mmio_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            dev_sel,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  uart_rx,
  output logic                  uart_tx,
  output logic                  tx_busy
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

  tx_state_t  tx_state, tx_next;
  logic [7:0] tx_byte;
  logic [2:0] tx_idx;
  logic       tx_tc, tx_accept;

  rx_state_t  rx_state, rx_next;
  logic [2:0] rx_sync;
  logic [7:0] rx_shift, rx_data;
  logic [2:0] rx_idx;
  logic       rx_tc, rx_line, rx_fall;
  logic       rx_valid, rx_ovr, frame_err;
  logic       byte_done, frame_bad, rx_rd_clr, stat_clr;
  logic       unused_wr_hi;

  assign unused_wr_hi = ^wr_data[DATA_WIDTH-1:8];

  // ---------------- transmitter ----------------
  assign tx_accept = wr_en && (dev_sel == DEV_TX) && (tx_state == T_IDLE);
  assign tx_busy   = (tx_state != T_IDLE);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk      (clk),
    .reset    (reset),
    .en       (tx_busy),
    .load     (tx_accept),
    .load_val (FULL_LOAD),
    .tc       (tx_tc)
  );

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      T_IDLE:  if (tx_accept) tx_next = T_START;
      T_START: if (tx_tc) tx_next = T_DATA;
      T_DATA:  if (tx_tc && tx_idx == 3'd7) tx_next = T_STOP;
      T_STOP:  if (tx_tc) tx_next = T_IDLE;
      default: tx_next = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= T_IDLE;
      tx_byte  <= '0;
      tx_idx   <= '0;
    end else begin
      tx_state <= tx_next;
      if (tx_accept) tx_byte <= wr_data[7:0];
      if (tx_state == T_DATA && tx_tc) tx_idx <= tx_idx + 1'b1;
    end
  end

  always_comb begin
    uart_tx = 1'b1;
    case (tx_state)
      T_START: uart_tx = 1'b0;
      T_DATA:  uart_tx = tx_byte[tx_idx];
      default: uart_tx = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  // rx_sync[1] is the synchronised line; rx_sync[2] is its previous value.
  assign rx_line = rx_sync[1];
  assign rx_fall = rx_sync[2] && !rx_sync[1];

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk      (clk),
    .reset    (reset),
    .en       (rx_state != R_IDLE),
    .load     (rx_state == R_IDLE && rx_fall),
    .load_val (HALF_LOAD),
    .tc       (rx_tc)
  );

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      R_IDLE:  if (rx_fall) rx_next = R_START;
      R_START: if (rx_tc) rx_next = rx_line ? R_IDLE : R_DATA;
      R_DATA:  if (rx_tc && rx_idx == 3'd7) rx_next = R_STOP;
      R_STOP:  if (rx_tc) rx_next = R_IDLE;
      default: rx_next = R_IDLE;
    endcase
  end

  assign byte_done = (rx_state == R_STOP) && rx_tc && rx_line;
  assign frame_bad = (rx_state == R_STOP) && rx_tc && !rx_line;
  assign rx_rd_clr = rd_en && (dev_sel == DEV_RX);
  assign stat_clr  = rd_en && (dev_sel == DEV_STAT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync   <= 3'b111;
      rx_state  <= R_IDLE;
      rx_shift  <= '0;
      rx_idx    <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_ovr    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[1:0], uart_rx};
      rx_state <= rx_next;
      if (rx_state == R_DATA && rx_tc) begin
        rx_shift[rx_idx] <= rx_line;
        rx_idx           <= rx_idx + 1'b1;
      end
      if (byte_done) rx_data <= rx_shift;
      // Set beats clear; a read retiring the old byte on the same edge is not an overrun.
      if (byte_done)      rx_valid <= 1'b1;
      else if (rx_rd_clr) rx_valid <= 1'b0;
      if (byte_done && rx_valid && !rx_rd_clr) rx_ovr <= 1'b1;
      else if (stat_clr)                       rx_ovr <= 1'b0;
      if (frame_bad)     frame_err <= 1'b1;
      else if (stat_clr) frame_err <= 1'b0;
    end
  end

  // ---------------- read mux ----------------
  always_comb begin
    rd_data = '0;
    case (dev_sel)
      DEV_TX: rd_data[7:0] = tx_byte;
      DEV_RX: rd_data[7:0] = rx_data;
      DEV_STAT: begin
        rd_data[ST_TXBUSY]  = tx_busy;
        rd_data[ST_RXVALID] = rx_valid;
        rd_data[ST_RXOVR]   = rx_ovr;
        rd_data[ST_FERR]    = frame_err;
      end
      default: rd_data = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_mmio_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_uart_mmio_ctrl
// Purpose  : Self-checking bench for uart_mmio_ctrl with a register-level model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_mmio_ctrl;
  import uart_pkg::*;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  dev_sel = DEV_NONE;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        uart_rx, uart_tx, tx_busy;
  logic        loop_en = 1'b0;
  logic        rx_drive = 1'b1;

  assign uart_rx = loop_en ? uart_tx : rx_drive;

  uart_mmio_ctrl #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .dev_sel (dev_sel),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int lat_meas = -1;

  // Register-level model of the software-visible state
  logic [7:0] m_rx_data = '0;
  logic [7:0] m_tx_byte = '0;
  logic       m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;

  function automatic logic [31:0] exp_status(input logic busy);
    return {28'h0, m_ferr, m_ovr, m_valid, busy};
  endfunction

  task automatic model_clear();
    m_rx_data = '0; m_tx_byte = '0; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit stop, input bit rd_during);
    if (rd_during) m_valid = 1'b0;
    if (stop) begin
      if (m_valid) m_ovr = 1'b1;
      m_valid   = 1'b1;
      m_rx_data = b;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [1:0] dev, input logic [7:0] b);
    dev_sel = dev; wr_en = 1'b1;
    wr_data = $urandom(); wr_data[7:0] = b;
    step();
    wr_en = 1'b0; dev_sel = DEV_NONE;
  endtask

  task automatic bus_read(input logic [1:0] dev, input bit rd, output logic [31:0] v);
    dev_sel = dev; rd_en = rd;
    #1 v = rd_data;
    step();
    rd_en = 1'b0; dev_sel = DEV_NONE;
    if (rd && dev == DEV_RX) m_valid = 1'b0;
    if (rd && dev == DEV_STAT) begin m_ovr = 1'b0; m_ferr = 1'b0; end
  endtask

  // Drive one serial frame on uart_rx while watching STATUS; optionally issue
  // an RX_DATA read during step rd_at.
  task automatic send_serial(input logic [7:0] b, input bit stop, input int rd_at,
                             output int lat, output logic [31:0] rd_seen);
    lat = -1; rd_seen = '0;
    for (int c = 0; c < 10 * CPB + 3; c++) begin
      int bi;
      bi = c / CPB;
      if (bi == 0)      rx_drive = 1'b0;
      else if (bi <= 8) rx_drive = b[bi-1];
      else if (bi == 9) rx_drive = stop;
      else              rx_drive = 1'b1;
      if (c == rd_at) begin dev_sel = DEV_RX; rd_en = 1'b1; end
      else begin dev_sel = DEV_STAT; rd_en = 1'b0; end
      #1;
      if (c == rd_at) rd_seen = rd_data;
      else if (lat < 0 && rd_data[ST_RXVALID]) lat = c;
      step();
    end
    rd_en = 1'b0; dev_sel = DEV_NONE; rx_drive = 1'b1;
  endtask

  // Write a byte and check the whole 10-bit frame; optionally inject a second
  // write while busy at cycle inj.
  task automatic tx_frame(input logic [7:0] b, input int inj, input logic [7:0] inj_b);
    logic expb;
    bus_write(DEV_TX, b);
    m_tx_byte = b;
    for (int c = 0; c < 10 * CPB; c++) begin
      if (c == inj) begin dev_sel = DEV_TX; wr_en = 1'b1; wr_data = {24'h0, inj_b}; end
      else if (c == inj + 1) begin wr_en = 1'b0; dev_sel = DEV_NONE; end
      #1;
      if (c < CPB)            expb = 1'b0;
      else if (c < 9 * CPB)   expb = b[c/CPB-1];
      else                    expb = 1'b1;
      vectors++;
      if (uart_tx !== expb) begin
        miscompares++;
        $display("FAIL tx_bit byte=%h cycle=%0d: uart_tx=%b expected %b", b, c, uart_tx, expb);
      end
      vectors++;
      if (tx_busy !== 1'b1) begin
        miscompares++;
        $display("FAIL tx_busy_high byte=%h cycle=%0d: tx_busy=%b expected 1", b, c, tx_busy);
      end
      step();
    end
    wr_en = 1'b0; dev_sel = DEV_NONE;
    #1;
    vectors++;
    if (tx_busy !== 1'b0 || uart_tx !== 1'b1) begin
      miscompares++;
      $display("FAIL tx_end byte=%h: busy=%b tx=%b expected busy=0 tx=1", b, tx_busy, uart_tx);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b0;
    repeat (3) step();
    vectors++;
    if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: tx=%b busy=%b expected tx=1 busy=0", uart_tx, tx_busy);
    end
    reset = 1'b1;
    model_clear();
    step();
    for (int d = 0; d < 4; d++) begin
      logic [31:0] e;
      bus_read(d[1:0], 1'b0, v);
      e = (d == 3) ? exp_status(1'b0) : 32'h0;
      vectors++;
      if (v !== e) begin
        miscompares++;
        $display("FAIL reset_read sel=%0d: rd_data=%h expected %h", d, v, e);
      end
    end
  endtask

  task automatic test_tx_basic();
    logic [31:0] v;
    tx_frame(8'h55, -10, 8'h00);
    step();
    tx_frame(8'($urandom()), -10, 8'h00);
    step();
    bus_read(DEV_TX, 1'b1, v);
    vectors++;
    if (v !== {24'h0, m_tx_byte}) begin
      miscompares++;
      $display("FAIL tx_readback: rd_data=%h expected %h", v, {24'h0, m_tx_byte});
    end
  endtask

  task automatic test_tx_ignore();
    logic [31:0] v;
    tx_frame(8'h55, 10, 8'hAA);
    step();
    bus_read(DEV_TX, 1'b0, v);
    vectors++;
    if (v !== 32'h55) begin
      miscompares++;
      $display("FAIL tx_ignore_readback: rd_data=%h expected 00000055", v);
    end
  endtask

  task automatic test_back_to_back();
    tx_frame(8'($urandom()), -10, 8'h00);
    tx_frame(8'($urandom()), -10, 8'h00);
    step();
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] v;
    bus_write(DEV_TX, 8'h00);
    repeat (20) step();
    reset = 1'b0;
    #1;
    vectors++;
    if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_frame: tx=%b busy=%b expected tx=1 busy=0", uart_tx, tx_busy);
    end
    step(); step();
    reset = 1'b1;
    model_clear();
    repeat (3) step();
    bus_read(DEV_STAT, 1'b0, v);
    vectors++;
    if (v !== 32'h0 || uart_tx !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_idle: status=%h tx=%b expected 00000000 tx=1", v, uart_tx);
    end
  endtask

  task automatic test_loopback();
    logic [31:0] v, e;
    bit seen;
    seen = 1'b0;
    loop_en = 1'b1;
    bus_write(DEV_TX, 8'hA5);
    m_tx_byte = 8'hA5;
    for (int i = 0; i < 200; i++) begin
      dev_sel = DEV_STAT;
      #1;
      if (rd_data[ST_RXVALID]) begin seen = 1'b1; break; end
      step();
    end
    model_frame(8'hA5, 1'b1, 1'b0);
    e = exp_status(1'b1);
    v = rd_data;
    vectors++;
    if (!seen || v !== e) begin
      miscompares++;
      $display("FAIL loopback_status: seen=%b status=%h expected %h", seen, v, e);
    end
    step();
    for (int i = 0; i < 40 && tx_busy; i++) step();
    loop_en = 1'b0;
    step();
    bus_read(DEV_RX, 1'b1, v);
    vectors++;
    if (v !== 32'hA5) begin
      miscompares++;
      $display("FAIL loopback_rxdata: rd_data=%h expected 000000a5", v);
    end
    bus_read(DEV_STAT, 1'b0, v);
    vectors++;
    if (v !== exp_status(1'b0)) begin
      miscompares++;
      $display("FAIL loopback_after_read: status=%h expected %h", v, exp_status(1'b0));
    end
  endtask

  task automatic test_two_bytes();
    logic [31:0] v, s;
    int lat;
    send_serial(8'h11, 1'b1, -1, lat, s);
    lat_meas = lat;
    model_frame(8'h11, 1'b1, 1'b0);
    send_serial(8'h22, 1'b1, -1, lat, s);
    model_frame(8'h22, 1'b1, 1'b0);
    bus_read(DEV_STAT, 1'b1, v);
    vectors++;
    if (v !== 32'h6) begin
      miscompares++;
      $display("FAIL two_bytes_status: status=%h expected 00000006", v);
    end
    bus_read(DEV_STAT, 1'b0, v);
    vectors++;
    if (v !== exp_status(1'b0)) begin
      miscompares++;
      $display("FAIL two_bytes_ovr_clear: status=%h expected %h", v, exp_status(1'b0));
    end
    bus_read(DEV_RX, 1'b1, v);
    vectors++;
    if (v !== 32'h22) begin
      miscompares++;
      $display("FAIL two_bytes_rxdata: rd_data=%h expected 00000022", v);
    end
    bus_read(DEV_STAT, 1'b0, v);
    vectors++;
    if (v !== 32'h0) begin
      miscompares++;
      $display("FAIL two_bytes_valid_clear: status=%h expected 00000000", v);
    end
  endtask

  task automatic test_frame_err_glitch();
    logic [31:0] v, s;
    int lat;
    logic [7:0] b;
    b = 8'($urandom());
    send_serial(b, 1'b0, -1, lat, s);
    model_frame(b, 1'b0, 1'b0);
    bus_read(DEV_STAT, 1'b0, v);
    vectors++;
    if (v !== exp_status(1'b0)) begin
      miscompares++;
      $display("FAIL frame_err_status: status=%h expected %h", v, exp_status(1'b0));
    end
    rx_drive = 1'b0;
    repeat (3) step();
    rx_drive = 1'b1;
    repeat (12) step();
    bus_read(DEV_STAT, 1'b0, v);
    vectors++;
    if (v !== exp_status(1'b0)) begin
      miscompares++;
      $display("FAIL glitch_status: status=%h expected %h", v, exp_status(1'b0));
    end
    bus_read(DEV_RX, 1'b0, v);
    vectors++;
    if (v !== {24'h0, m_rx_data}) begin
      miscompares++;
      $display("FAIL glitch_rxdata: rd_data=%h expected %h", v, {24'h0, m_rx_data});
    end
  endtask

  task automatic test_read_collision();
    logic [31:0] v, s;
    int lat;
    logic [7:0] b1, b2;
    b1 = 8'($urandom()); b2 = ~b1;
    bus_read(DEV_STAT, 1'b1, v);
    bus_read(DEV_RX, 1'b1, v);
    if (lat_meas < 1) begin
      vectors++; miscompares++;
      $display("FAIL rx_latency: measured=%0d expected >0", lat_meas);
      return;
    end
    send_serial(b1, 1'b1, -1, lat, s);
    model_frame(b1, 1'b1, 1'b0);
    send_serial(b2, 1'b1, lat_meas - 1, lat, s);
    vectors++;
    if (s !== {24'h0, m_rx_data}) begin
      miscompares++;
      $display("FAIL collision_read: rd_data=%h expected %h", s, {24'h0, m_rx_data});
    end
    model_frame(b2, 1'b1, 1'b1);
    bus_read(DEV_STAT, 1'b0, v);
    vectors++;
    if (v !== exp_status(1'b0)) begin
      miscompares++;
      $display("FAIL collision_status: status=%h expected %h", v, exp_status(1'b0));
    end
    bus_read(DEV_RX, 1'b0, v);
    vectors++;
    if (v !== {24'h0, b2}) begin
      miscompares++;
      $display("FAIL collision_rxdata: rd_data=%h expected %h", v, {24'h0, b2});
    end
  endtask

  task automatic test_random_rx();
    logic [31:0] v, s, e;
    logic [7:0] b;
    bit stop;
    int rd_at, lat, act;
    for (int n = 0; n < 10; n++) begin
      b     = 8'($urandom());
      stop  = ($urandom_range(0, 3) != 0);
      rd_at = -1;
      if (lat_meas > 1 && $urandom_range(0, 2) == 0) rd_at = $urandom_range(0, lat_meas - 1);
      e = {24'h0, m_rx_data};
      send_serial(b, stop, rd_at, lat, s);
      if (rd_at >= 0) begin
        vectors++;
        if (s !== e) begin
          miscompares++;
          $display("FAIL rand_mid_read n=%0d: rd_data=%h expected %h", n, s, e);
        end
      end
      model_frame(b, stop, rd_at >= 0);
      act = $urandom_range(0, 3);
      if (act[0]) begin
        e = exp_status(1'b0);
        bus_read(DEV_STAT, 1'b1, v);
        vectors++;
        if (v !== e) begin
          miscompares++;
          $display("FAIL rand_stat_read n=%0d: status=%h expected %h", n, v, e);
        end
      end
      if (act[1]) begin
        e = {24'h0, m_rx_data};
        bus_read(DEV_RX, 1'b1, v);
        vectors++;
        if (v !== e) begin
          miscompares++;
          $display("FAIL rand_rx_read n=%0d: rd_data=%h expected %h", n, v, e);
        end
      end
      bus_read(DEV_STAT, 1'b0, v);
      vectors++;
      if (v !== exp_status(1'b0)) begin
        miscompares++;
        $display("FAIL rand_status n=%0d: status=%h expected %h", n, v, exp_status(1'b0));
      end
      bus_read(DEV_RX, 1'b0, v);
      vectors++;
      if (v !== {24'h0, m_rx_data}) begin
        miscompares++;
        $display("FAIL rand_rxdata n=%0d: rd_data=%h expected %h", n, v, {24'h0, m_rx_data});
      end
    end
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_ignore();
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback();
    test_two_bytes();
    test_frame_err_glitch();
    test_read_collision();
    test_random_rx();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
